// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared definitions for the UART receiver: FSM state
//                encoding, parity mode constants (common with the
//                transmitter) and a small parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

    // FSM state encoding
    localparam int         c_STATE_W  = 3;
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Parity mode constants, shared with the transmitter
    localparam logic c_PARITY_EVEN = 1'b1;
    localparam logic c_PARITY_ODD  = 1'b0;

    // Width of the data bit counter (covers up to 8 data bits)
    localparam int c_BIT_CNT_W = 3;

    // Expected parity bit given the XOR-reduction of the data bits.
    // Even parity: the bit makes the total count of ones even.
    function automatic logic expected_parity(input logic data_xor, input logic mode);
        return (mode == c_PARITY_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchroniser for the asynchronous serial line.
//                Both flops reset to 1 so the line reads idle after reset.
//  Ports       : clk     - system clock
//                rst     - asynchronous active-high reset
//                i_async - asynchronous input
//                o_sync  - synchronised output
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART serial receiver. Oversamples the line, detects the
//                start bit, samples each bit at mid-bit, deserialises
//                LSB-first, checks optional parity and the stop bit, and
//                presents each byte with a 1-cycle valid pulse.
//  Ports       : clk        - system clock (rising edge)
//                rst        - asynchronous active-high reset
//                Rx_s       - serial line, idle high, asynchronous
//                prescale   - clocks per bit minus 1
//                rx_data    - last frame received with a good stop bit
//                data_valid - 1-cycle pulse, rx_data updated
//                parity_err - parity mismatch, valid with data_valid
//                frame_err  - 1-cycle pulse, stop bit sampled low
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_SIZE           = 8,
    parameter int SAMPLING_CNTR_WIDTH = 4,
    parameter int PARITY_ON           = 1,
    parameter int EVEN_PARITY         = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           Rx_s,
    input  logic [SAMPLING_CNTR_WIDTH-1:0] prescale,
    output logic [DATA_SIZE-1:0]           rx_data,
    output logic                           data_valid,
    output logic                           parity_err,
    output logic                           frame_err
);

    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT   = c_BIT_CNT_W'(DATA_SIZE - 1);
    localparam logic                   c_PARITY_EN  = (PARITY_ON != 0);
    localparam logic                   c_PARITY_MODE = (EVEN_PARITY != 0) ? c_PARITY_EVEN : c_PARITY_ODD;

    logic                           w_rx_sync;
    logic [SAMPLING_CNTR_WIDTH-1:0] w_half;
    logic                           w_par_exp;

    logic [c_STATE_W-1:0]           r_state;
    logic [SAMPLING_CNTR_WIDTH-1:0] r_s_cnt;
    logic [SAMPLING_CNTR_WIDTH-1:0] r_prescale;
    logic [c_BIT_CNT_W-1:0]         r_bit_cnt;
    logic [DATA_SIZE-1:0]           r_shreg;
    logic                           r_p_err;
    logic                           r_break;
    logic [DATA_SIZE-1:0]           r_rx_data;
    logic                           r_data_valid;
    logic                           r_parity_err;
    logic                           r_frame_err;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (Rx_s),
        .o_sync  (w_rx_sync)
    );

    // Start-bit check point: half a bit period after the falling edge
    assign w_half    = r_prescale >> 1;
    assign w_par_exp = expected_parity(^r_shreg, c_PARITY_MODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_s_cnt      <= '0;
            r_prescale   <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_p_err      <= 1'b0;
            r_break      <= 1'b0;
            r_rx_data    <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            // Output strobes are single-cycle by default
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    r_s_cnt   <= '0;
                    r_bit_cnt <= '0;
                    // After a framing error the line may still be held low
                    // (break); wait for it to return high before re-arming.
                    if (w_rx_sync) begin
                        r_break <= 1'b0;
                    end
                    if (!w_rx_sync && !r_break) begin
                        r_state    <= c_ST_START;
                        r_prescale <= prescale;
                    end
                end

                c_ST_START: begin
                    if (r_s_cnt == w_half) begin
                        r_s_cnt <= '0;
                        // Line back high at mid-start means a glitch
                        r_state <= w_rx_sync ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_s_cnt <= r_s_cnt + 1'b1;
                    end
                end

                c_ST_DATA: begin
                    if (r_s_cnt == r_prescale) begin
                        r_s_cnt            <= '0;
                        r_shreg[r_bit_cnt] <= w_rx_sync;
                        r_bit_cnt          <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state <= c_PARITY_EN ? c_ST_PARITY : c_ST_STOP;
                        end
                    end else begin
                        r_s_cnt <= r_s_cnt + 1'b1;
                    end
                end

                c_ST_PARITY: begin
                    if (r_s_cnt == r_prescale) begin
                        r_s_cnt <= '0;
                        r_p_err <= w_rx_sync ^ w_par_exp;
                        r_state <= c_ST_STOP;
                    end else begin
                        r_s_cnt <= r_s_cnt + 1'b1;
                    end
                end

                c_ST_STOP: begin
                    if (r_s_cnt == r_prescale) begin
                        r_s_cnt <= '0;
                        r_state <= c_ST_IDLE;
                        if (w_rx_sync) begin
                            r_rx_data    <= r_shreg;
                            r_data_valid <= 1'b1;
                            r_parity_err <= c_PARITY_EN ? r_p_err : 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_break     <= 1'b1;
                        end
                    end else begin
                        r_s_cnt <= r_s_cnt + 1'b1;
                    end
                end

                default: begin
                    r_s_cnt <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Stimulus pushes expected
//                results into a scoreboard queue; a monitor pops and
//                compares whenever the receiver raises an output strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int BIT_CLKS = 16;   // prescale 15

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Rx_s = 1'b1;
    logic [3:0] prescale = 4'd15;
    logic [7:0] rx_data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;

    uart_rx #(
        .DATA_SIZE           (8),
        .SAMPLING_CNTR_WIDTH (4),
        .PARITY_ON           (1),
        .EVEN_PARITY         (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rx_s       (Rx_s),
        .prescale   (prescale),
        .rx_data    (rx_data),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    exp_t       sb[$];
    exp_t       r_exp;
    int         errors = 0;
    int         checks = 0;
    int         n_events = 0;
    int         cyc = 0;
    int         valid_cyc[$];
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Even parity bit: set when the data has an odd number of ones
    function automatic bit ref_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 1;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err)) begin
            n_events++;
            check("exclusive_strobes", {31'd0, data_valid & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: dv=%0b fe=%0b data=%0h, nothing expected",
                         data_valid, frame_err, rx_data);
            end else begin
                r_exp = sb.pop_front();
                check("frame_err", {31'd0, frame_err}, {31'd0, r_exp.ferr});
                check("rx_data", {24'd0, rx_data}, {24'd0, r_exp.data});
                if (!r_exp.ferr)
                    check("parity_err", {31'd0, parity_err}, {31'd0, r_exp.perr});
                if (data_valid) valid_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive_bit(input logic b);
        Rx_s = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        Rx_s = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Push the expected outcome, then serialise the frame LSB-first
    task automatic send_frame(input logic [7:0] d, input bit par_bit, input bit stop_bit);
        exp_t e;
        if (stop_bit) begin
            e.ferr = 1'b0;
            e.data = d;
            e.perr = (par_bit != ref_parity(d));
            last_good = d;
        end else begin
            e.ferr = 1'b1;
            e.data = last_good;
            e.perr = 1'b0;
        end
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    initial begin
        int         ev0;
        int         k;
        logic [7:0] d;
        bit         bad_par;
        bit         bad_stop;

        repeat (3) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_data_valid", {31'd0, data_valid}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        idle(20);

        // Good frame, correct parity
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(16);
        // Parity error
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(16);
        // Bad stop bit: frame dropped, rx_data keeps 0x3C
        send_frame(8'h81, ref_parity(8'h81), 1'b0);
        idle(32);

        // Short glitch must be rejected
        ev0 = n_events;
        Rx_s = 1'b0;
        repeat (4) @(negedge clk);
        idle(60);
        check("glitch_no_output", n_events, ev0);

        // Back-to-back frames, zero idle gap
        k = valid_cyc.size();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(16);
        check("b2b_two_pulses", valid_cyc.size() - k, 2);
        if (valid_cyc.size() - k == 2)
            check("b2b_spacing", valid_cyc[k+1] - valid_cyc[k], 176);

        // Reset mid-DATA of 0x55 (start + bits 1,0,1)
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        #3 rst = 1'b1;
        #1;
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_data_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        last_good = 8'h00;
        Rx_s = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(40);
        send_frame(8'h12, ref_parity(8'h12), 1'b1);
        idle(16);

        // Randomised frames
        for (int n = 0; n < 30; n++) begin
            d        = 8'($urandom);
            bad_par  = ($urandom_range(0, 3) == 0);
            bad_stop = ($urandom_range(0, 4) == 0);
            send_frame(d, ref_parity(d) ^ bad_par, !bad_stop);
            idle(bad_stop ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 24)));
        end

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
